// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer/flag control of an async FIFO: wptr crosses via a 2-flop sync, flags registered.
// Read accepted same cycle as rinc when not empty; rinc while empty is dropped and flagged sticky.
module fifo_rd_ctrl #(
    parameter int ADDRSIZE      = 4,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   wptr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                raempty,
    output logic [ADDRSIZE:0]   rlevel,
    output logic                runderflow
);

    logic [ADDRSIZE:0] rq1_wptr_q, rq1_wptr_d;
    logic [ADDRSIZE:0] rq2_wptr_q, rq2_wptr_d;
    logic [ADDRSIZE:0] rbin_q, rbin_d;
    logic [ADDRSIZE:0] rptr_q, rptr_d;
    logic [ADDRSIZE:0] rlevel_q, rlevel_d;
    logic              rempty_q, rempty_d;
    logic              raempty_q, raempty_d;
    logic              runderflow_q, runderflow_d;
    logic [ADDRSIZE:0] wbin_s;
    logic              rd_acc;

    always_comb begin
        rq1_wptr_d = wptr;
        rq2_wptr_d = rq1_wptr_q;

        rd_acc = rinc & ~rempty_q;
        rbin_d = rbin_q + {{ADDRSIZE{1'b0}}, rd_acc};
        rptr_d = (rbin_d >> 1) ^ rbin_d;

        // Gray to binary: each bit is the XOR of itself and all higher bits.
        wbin_s = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            wbin_s[i] = ^(rq2_wptr_q >> i);
        end

        rlevel_d     = wbin_s - rbin_d;
        rempty_d     = (rptr_d == rq2_wptr_q);
        raempty_d    = rempty_d | (int'(rlevel_d) <= AEMPTY_THRESH);
        runderflow_d = runderflow_q | (rinc & rempty_q);
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rq1_wptr_q   <= '0;
            rq2_wptr_q   <= '0;
            rbin_q       <= '0;
            rptr_q       <= '0;
            rlevel_q     <= '0;
            rempty_q     <= 1'b1;
            raempty_q    <= 1'b1;
            runderflow_q <= 1'b0;
        end else begin
            rq1_wptr_q   <= rq1_wptr_d;
            rq2_wptr_q   <= rq2_wptr_d;
            rbin_q       <= rbin_d;
            rptr_q       <= rptr_d;
            rlevel_q     <= rlevel_d;
            rempty_q     <= rempty_d;
            raempty_q    <= raempty_d;
            runderflow_q <= runderflow_d;
        end
    end

    assign raddr      = rbin_q[ADDRSIZE-1:0];
    assign rptr       = rptr_q;
    assign rempty     = rempty_q;
    assign raempty    = raempty_q;
    assign rlevel     = rlevel_q;
    assign runderflow = runderflow_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: constant vector table, hand sequences, and random traffic vs. a counting model.
module tb_fifo_rd_ctrl;

    localparam int AS    = 4;
    localparam int DEPTH = 1 << AS;
    localparam int PMOD  = 2 * DEPTH;
    localparam int THR   = 2;

    logic          rclk = 1'b0;
    logic          rrst = 1'b1;
    logic          rinc = 1'b0;
    logic [AS:0]   wptr = '0;
    logic [AS-1:0] raddr;
    logic [AS:0]   rptr;
    logic          rempty, raempty, runderflow;
    logic [AS:0]   rlevel;

    fifo_rd_ctrl #(.ADDRSIZE(AS), .AEMPTY_THRESH(THR)) dut (
        .rclk(rclk), .rrst(rrst), .rinc(rinc), .wptr(wptr),
        .raddr(raddr), .rptr(rptr), .rempty(rempty), .raempty(raempty),
        .rlevel(rlevel), .runderflow(runderflow)
    );

    always #5 rclk = ~rclk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state: total words written/read as plain counters plus
    // the two-deep delayed view of the write count seen by the reader.
    int wtot = 0, rtot = 0;
    int s1 = 0, s2 = 0;
    int m_level = 0;
    bit m_empty = 1, m_aempty = 1, m_und = 0;

    function automatic logic [AS:0] to_gray(input int b);
        logic [AS:0] x;
        x = AS'(0);
        x = b[AS:0];
        return x ^ (x >> 1);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit inc);
        rrst = rst;
        rinc = inc;
        wptr = to_gray(wtot % PMOD);
        @(posedge rclk);
        #1;
        if (rst) begin
            s1 = 0; s2 = 0; rtot = 0;
            m_level = 0; m_empty = 1; m_aempty = 1; m_und = 0;
        end else begin
            if (inc && m_empty) m_und = 1;
            if (inc && !m_empty) rtot++;
            m_level  = (((s2 - rtot) % PMOD) + PMOD) % PMOD;
            m_empty  = (m_level == 0);
            m_aempty = (m_level <= THR);
            s2 = s1;
            s1 = wtot;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".rempty"},     rempty,     m_empty);
        chk({tag, ".raempty"},    raempty,    m_aempty);
        chk({tag, ".rlevel"},     rlevel,     m_level);
        chk({tag, ".raddr"},      raddr,      rtot % DEPTH);
        chk({tag, ".rptr"},       rptr,       to_gray(rtot % PMOD));
        chk({tag, ".runderflow"}, runderflow, m_und);
    endtask

    // Write n words, let them cross the synchronizer, then read them all.
    task automatic fill_and_drain(input int n);
        wtot += n;
        for (int i = 0; i < 3; i++) begin step(0, 0); check_model("fill"); end
        for (int i = 0; i < n; i++) begin step(0, 1); check_model("drain"); end
    endtask

    typedef struct {
        bit rst; bit inc; int wb;
        bit e; bit ae; int lvl; int addr; int ptr; bit und;
    } vec_t;

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{1, 0, 0,  1, 1, 0,  0, 0, 0};
        tbl[1]  = '{0, 0, 3,  1, 1, 0,  0, 0, 0};
        tbl[2]  = '{0, 0, 3,  1, 1, 0,  0, 0, 0};
        tbl[3]  = '{0, 0, 3,  0, 0, 3,  0, 0, 0};
        tbl[4]  = '{0, 1, 3,  0, 1, 2,  1, 1, 0};
        tbl[5]  = '{0, 1, 3,  0, 1, 1,  2, 3, 0};
        tbl[6]  = '{0, 1, 3,  1, 1, 0,  3, 2, 0};
        tbl[7]  = '{0, 1, 3,  1, 1, 0,  3, 2, 1};
        tbl[8]  = '{1, 1, 16, 1, 1, 0,  0, 0, 0};
        tbl[9]  = '{0, 0, 16, 1, 1, 0,  0, 0, 0};
        tbl[10] = '{0, 0, 16, 1, 1, 0,  0, 0, 0};
        tbl[11] = '{0, 0, 16, 0, 0, 16, 0, 0, 0};
        tbl[12] = '{0, 1, 16, 0, 0, 15, 1, 1, 0};
        tbl[13] = '{1, 1, 16, 1, 1, 0,  0, 0, 0};

        for (int i = 0; i < 14; i++) begin
            wtot = tbl[i].wb;
            step(tbl[i].rst, tbl[i].inc);
            chk($sformatf("vec%0d.rempty", i),     rempty,     tbl[i].e);
            chk($sformatf("vec%0d.raempty", i),    raempty,    tbl[i].ae);
            chk($sformatf("vec%0d.rlevel", i),     rlevel,     tbl[i].lvl);
            chk($sformatf("vec%0d.raddr", i),      raddr,      tbl[i].addr);
            chk($sformatf("vec%0d.rptr", i),       rptr,       tbl[i].ptr);
            chk($sformatf("vec%0d.runderflow", i), runderflow, tbl[i].und);
        end

        // Pointer wrap: bring rbin to 31, then read across the 31 -> 0 boundary.
        wtot = 0;
        step(1, 0);
        fill_and_drain(16);
        fill_and_drain(15);
        chk("wrap.rptr_at_31", rptr, 5'b10000);
        wtot = 32;
        for (int i = 0; i < 3; i++) step(0, 0);
        chk("wrap.level_before", rlevel, 1);
        step(0, 1);
        chk("wrap.rptr_after", rptr, 5'b00000);
        chk("wrap.raddr_after", raddr, 0);
        chk("wrap.rempty_after", rempty, 1);
        check_model("wrap");

        // Reset mid-activity with level 5 and underflow already set.
        wtot = 0;
        step(1, 0);
        step(0, 1);
        chk("rst.und_set", runderflow, 1);
        wtot = 5;
        for (int i = 0; i < 3; i++) step(0, 0);
        chk("rst.level5", rlevel, 5);
        step(1, 1);
        chk("rst.rptr", rptr, 0);
        chk("rst.raddr", raddr, 0);
        chk("rst.rempty", rempty, 1);
        chk("rst.raempty", raempty, 1);
        chk("rst.rlevel", rlevel, 0);
        chk("rst.runderflow", runderflow, 0);
        wtot = 0;
        step(0, 1);
        check_model("post_rst");

        // Random traffic with multi-word write bursts and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            bit rst_r, inc_r;
            int room;
            rst_r = ($urandom % 100) == 0;
            inc_r = ($urandom % 4) != 0;
            room  = DEPTH - (wtot - rtot);
            if (rst_r) wtot = 0;
            else if (room > 0 && ($urandom % 2) == 1)
                wtot += $urandom_range(1, (room < 3) ? room : 3);
            step(rst_r, inc_r);
            check_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
